// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  // Access width codes, matching funct3[1:0] of loads/stores.
  localparam logic [1:0] W_BYTE = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_WORD = 2'b10;

  localparam logic [31:0] RESET_ADDR = 32'h0040_0000;

endpackage

// File: rtl/mem_arb_pick.sv
// Owner selection: data side wins unless the starvation guard forces the fetch side.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
  input  logic   starve_hit,
  output owner_t owner,
  output logic   any
);

  always_comb begin
    any = i_req | d_req;
    if (i_req && (starve_hit || !d_req)) begin
      owner = OWN_I;
    end else begin
      owner = OWN_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch (I) and data (D).
// Define MEM_ARB_STARVE_GUARD_EN to force an I grant after STARVE_LIMIT back-to-back D grants.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [1:0]    d_width,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [1:0]    mem_width,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata
);

  state_t state, state_nxt;
  owner_t owner_q, pick_owner;
  logic   pick_any;
  logic   starve_hit;
  logic   issue, done;
  logic   i_gnt_nxt, d_gnt_nxt, i_rvalid_nxt, d_rvalid_nxt;

  mem_arb_pick u_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .starve_hit (starve_hit),
    .owner      (pick_owner),
    .any        (pick_any)
  );

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);
  logic [2:0] starve_cnt;

  // Counts D grants issued while a fetch was left waiting; saturates rather than wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (i_gnt) begin
      starve_cnt <= '0;
    end else if (d_gnt && i_req && (starve_cnt != 3'h7)) begin
      starve_cnt <= starve_cnt + 3'd1;
    end
  end

  assign starve_hit = (starve_cnt == LIMIT);
`else
  assign starve_hit = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: default assignment first so no path through the case leaves state_nxt unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (pick_any) state_nxt = ISSUE;
      ISSUE:   state_nxt = mem_ack ? IDLE : WAIT;
      WAIT:    if (mem_ack)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered strobes; an ack seen in IDLE never counts as completion.
  always_comb begin
    issue        = (state == IDLE) && pick_any;
    done         = (state != IDLE) && mem_ack;
    i_gnt_nxt    = issue && (pick_owner == OWN_I);
    d_gnt_nxt    = issue && (pick_owner == OWN_D);
    i_rvalid_nxt = done && (owner_q == OWN_I);
    d_rvalid_nxt = done && (owner_q == OWN_D);
  end

  // NOTE: every output register has an explicit reset value; there is no storage array here to leave unreset.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q   <= OWN_I;
      i_gnt     <= 1'b0;
      d_gnt     <= 1'b0;
      mem_req   <= 1'b0;
      i_rvalid  <= 1'b0;
      d_rvalid  <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_width <= W_WORD;
      mem_wdata <= '0;
    end else begin
      i_gnt    <= i_gnt_nxt;
      d_gnt    <= d_gnt_nxt;
      mem_req  <= issue;
      i_rvalid <= i_rvalid_nxt;
      d_rvalid <= d_rvalid_nxt;
      if (issue) begin
        owner_q <= pick_owner;
        if (pick_owner == OWN_D) begin
          mem_we    <= d_we;
          mem_addr  <= d_addr;
          mem_width <= d_width;
          mem_wdata <= d_wdata;
        end else begin
          mem_we    <= 1'b0;
          mem_addr  <= i_addr;
          mem_width <= W_WORD;
          mem_wdata <= '0;
        end
      end
      if (i_rvalid_nxt) i_rdata <= mem_rdata;
      // A store completion leaves the last load data in place.
      if (d_rvalid_nxt && !mem_we) d_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a simple ack-delay memory responder.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_gnt, i_rvalid;
  logic [DW-1:0] i_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [1:0]    d_width = W_WORD;
  logic [DW-1:0] d_wdata = '0;
  logic          d_gnt, d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [1:0]    mem_width;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;

  int            ack_delay = 1;
  logic [DW-1:0] rsp_data = '0;
  int            n_vec = 0;
  int            n_err = 0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_gnt     (i_gnt),
    .i_rvalid  (i_rvalid),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_width   (d_width),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_width (mem_width),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory model: acks ack_delay cycles after seeing mem_req (0 = same cycle as the issue).
  initial begin
    forever begin
      tick();
      if (mem_req && !rst) begin
        for (int k = 0; k < ack_delay; k++) tick();
        mem_ack   = 1'b1;
        mem_rdata = rsp_data;
        tick();
        mem_ack = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] exp_seq;
    logic [5:0] got_seq;
    int         n_gnt;
    logic       stray;

    // Reset state
    repeat (3) tick();
    rst = 1'b0;
    check("rst_i_gnt", i_gnt, 1'b0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_width", mem_width, W_WORD);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_rvalid", {d_rvalid, i_rvalid}, 2'b00);

    // 1: single fetch, ack one cycle after mem_req
    ack_delay = 1;
    rsp_data  = 32'h0000_0013;
    i_req = 1'b1; i_addr = RESET_ADDR;
    tick();
    check("t1_i_gnt", i_gnt, 1'b1);
    check("t1_mem_req", mem_req, 1'b1);
    check("t1_mem_addr", mem_addr, RESET_ADDR);
    check("t1_d_gnt", d_gnt, 1'b0);
    i_req = 1'b0;
    tick();
    check("t1_early_rvalid", i_rvalid, 1'b0);
    tick();
    check("t1_i_rvalid", i_rvalid, 1'b1);
    check("t1_i_rdata", i_rdata, 32'h0000_0013);
    check("t1_d_rvalid", d_rvalid, 1'b0);
    tick();
    check("t1_rvalid_pulse", i_rvalid, 1'b0);

    // 2: simultaneous requests, D first then I three cycles later
    rsp_data = 32'hCAFE_F00D;
    i_req = 1'b1; i_addr = 32'h0040_0004;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1001_0004; d_width = W_WORD;
    tick();
    check("t2_d_gnt", d_gnt, 1'b1);
    check("t2_i_gnt", i_gnt, 1'b0);
    check("t2_mem_addr", mem_addr, 32'h1001_0004);
    check("t2_mem_we", mem_we, 1'b0);
    d_req = 1'b0;
    tick();
    tick();
    check("t2_d_rvalid", d_rvalid, 1'b1);
    check("t2_d_rdata", d_rdata, 32'hCAFE_F00D);
    check("t2_i_rvalid", i_rvalid, 1'b0);
    rsp_data = 32'h1111_1111;
    tick();
    check("t2_i_gnt_late", i_gnt, 1'b1);
    check("t2_i_addr", mem_addr, 32'h0040_0004);
    i_req = 1'b0;
    tick();
    tick();
    check("t2_i_rvalid", i_rvalid, 1'b1);
    check("t2_i_rdata", i_rdata, 32'h1111_1111);
    tick();

    // 3: store with a slow memory
    ack_delay = 5;
    rsp_data  = 32'h55AA_55AA;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1001_0008; d_width = W_WORD; d_wdata = 32'hDEAD_BEEF;
    tick();
    check("t3_d_gnt", d_gnt, 1'b1);
    check("t3_mem_we", mem_we, 1'b1);
    d_req = 1'b0; d_we = 1'b0; d_wdata = '0;
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("t3_wdata_hold%0d", c), mem_wdata, 32'hDEAD_BEEF);
      check($sformatf("t3_no_rvalid%0d", c), d_rvalid, 1'b0);
    end
    tick();
    check("t3_d_rvalid", d_rvalid, 1'b1);
    check("t3_d_rdata_kept", d_rdata, 32'hCAFE_F00D);
    tick();

    // 5: reset while waiting; the late ack must be ignored
    ack_delay = 4;
    rsp_data  = 32'h0000_0099;
    i_req = 1'b1; i_addr = 32'h0040_0008;
    tick();
    check("t5_i_gnt", i_gnt, 1'b1);
    i_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_rst_i_rdata", i_rdata, 32'h0);
    check("t5_rst_mem_addr", mem_addr, 32'h0);
    check("t5_rst_mem_width", mem_width, W_WORD);
    check("t5_rst_mem_req", mem_req, 1'b0);
    stray = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      stray = stray | i_rvalid | d_rvalid | mem_req;
    end
    check("t5_late_ack_ignored", stray, 1'b0);
    ack_delay = 1;
    rsp_data  = 32'h0000_0077;
    i_req = 1'b1; i_addr = 32'h0040_000C;
    tick();
    check("t5_next_gnt", i_gnt, 1'b1);
    i_req = 1'b0;
    tick();
    tick();
    check("t5_next_rvalid", i_rvalid, 1'b1);
    check("t5_next_rdata", i_rdata, 32'h0000_0077);
    tick();

    // 6: zero-wait memory acks in the issue cycle
    ack_delay = 0;
    rsp_data  = 32'h0000_00AB;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1001_0010; d_width = W_BYTE;
    tick();
    check("t6_d_gnt", d_gnt, 1'b1);
    check("t6_mem_width", mem_width, W_BYTE);
    d_req = 1'b0;
    tick();
    check("t6_d_rvalid", d_rvalid, 1'b1);
    check("t6_d_rdata", d_rdata, 32'h0000_00AB);
    check("t6_no_req", mem_req, 1'b0);
    stray = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      stray = stray | mem_req | d_rvalid;
    end
    check("t6_no_stray", stray, 1'b0);

    // 4: both requesters held high; record the first six grants (1 = D, 0 = I)
    ack_delay = 1;
    rsp_data  = 32'h0000_0001;
`ifdef MEM_ARB_STARVE_GUARD_EN
    exp_seq = 6'b101111;
`else
    exp_seq = 6'b111111;
`endif
    got_seq = '0;
    n_gnt   = 0;
    i_req = 1'b1; i_addr = 32'h0040_0010;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1001_0020; d_width = W_WORD;
    for (int c = 0; c < 60 && n_gnt < 6; c++) begin
      tick();
      if (d_gnt || i_gnt) begin
        got_seq[n_gnt] = d_gnt;
        n_gnt++;
      end
    end
    check("t4_grant_count", n_gnt, 6);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("t4_grant%0d_is_d", k), got_seq[k], exp_seq[k]);
    end
    i_req = 1'b0;
    d_req = 1'b0;
    repeat (6) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
